vector_beam_integrator: RTL and testbench

- Receive end of the vector-generator output interface; emulates the analog X/Y beam integrators.
- Accepts the latched, sign-inverted (offset-binary) DVX/DVY vector pair, the linear scale and a draw length from the vector state machine.
- Steps a digital beam position along the vector, one step per clock, while driving a Z (intensity) strobe.
- Feeds the MiSTer vector rasterizer with beam X/Y/Z samples, one per clock.

---
 rtl/vector_beam_integrator.sv | 150 +++++++++++++++
 tb/tb_vector_beam_integrator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_beam_integrator.sv
// Digital stand-in for the analog X/Y beam integrators: steps a saturating fixed-point beam along each vector.
// Latency: handshake edge -> first beam_valid 2 clocks, done 2+len clocks after it; a command occupies len+3 clocks.
// Backpressure: vec_ready is high only in IDLE with no center pulse; beam samples are never stalled.
module vector_beam_integrator #(
    parameter int POS_W  = 10,
    parameter int FRAC_W = 12,
    parameter int LEN_W  = 10,
    parameter int CENTER = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [12:0]      dvx,
    input  logic [12:0]      dvy,
    input  logic [7:0]       linscale,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       zval,
    input  logic             center,
    output logic [POS_W-1:0] beam_x,
    output logic [POS_W-1:0] beam_y,
    output logic [3:0]       beam_z,
    output logic             beam_valid,
    output logic             clipped,
    output logic             done
);

    localparam int ACC_W = POS_W + FRAC_W;
    localparam logic [ACC_W-1:0] ACC_CENTER = ACC_W'(CENTER) << FRAC_W;
    localparam logic [ACC_W-1:0] ACC_MAX    = {{POS_W{1'b1}}, {FRAC_W{1'b0}}};
    localparam logic [POS_W-1:0] POS_CENTER = POS_W'(CENTER);

    typedef enum logic [1:0] {S_IDLE, S_SCALE, S_DRAW, S_FIN} state_t;

    state_t             state;
    logic [12:0]        dvx_q, dvy_q;
    logic [7:0]         scale_q;
    logic [LEN_W-1:0]   len_q, cnt_q;
    logic [3:0]         zval_q;
    logic [12:0]        step_x_q, step_y_q;
    logic [ACC_W-1:0]   acc_x_q, acc_y_q;

    // Adds a signed step to an unsigned accumulator; the top result bit flags a clamp.
    // The 2-bit headroom makes bit ACC_W+1 a pure underflow flag and bit ACC_W a pure overflow flag,
    // because |step| is far smaller than the accumulator range.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [12:0] step);
        logic [ACC_W+1:0] sum;
        sum = {2'b00, acc} + {{(ACC_W-11){step[12]}}, step};
        if (sum[ACC_W+1])
            return {1'b1, {ACC_W{1'b0}}};
        else if (sum[ACC_W])
            return {1'b1, ACC_MAX};
        else
            return {1'b0, sum[ACC_W-1:0]};
    endfunction

    // Offset-binary to two's complement is a flip of the top bit.
    logic [12:0] dx_s, dy_s;
    logic [8:0]  mult;
    assign dx_s = {~dvx_q[12], dvx_q[11:0]};
    assign dy_s = {~dvy_q[12], dvy_q[11:0]};
    assign mult = {1'b0, scale_q} + 9'd1;

    // 21 bits hold +-4096*256; dropping the low 8 bits is an arithmetic (floor) shift.
    logic signed [20:0] prod_x, prod_y;
    assign prod_x = $signed({{8{dx_s[12]}}, dx_s}) * $signed({12'd0, mult});
    assign prod_y = $signed({{8{dy_s[12]}}, dy_s}) * $signed({12'd0, mult});

    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_x[7:0], prod_y[7:0]};

    logic [ACC_W:0] next_x, next_y;
    assign next_x = sat_add(acc_x_q, step_x_q);
    assign next_y = sat_add(acc_y_q, step_y_q);

    // A center pulse blocks acceptance in the same cycle so it always wins over a new command.
    assign vec_ready = (state == S_IDLE) && !center;

    // Vector sequencer: capture, scale, integrate len steps, report completion; center overrides all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            dvx_q      <= '0;
            dvy_q      <= '0;
            scale_q    <= '0;
            len_q      <= '0;
            zval_q     <= '0;
            step_x_q   <= '0;
            step_y_q   <= '0;
            cnt_q      <= '0;
            acc_x_q    <= ACC_CENTER;
            acc_y_q    <= ACC_CENTER;
            beam_x     <= POS_CENTER;
            beam_y     <= POS_CENTER;
            beam_z     <= '0;
            beam_valid <= 1'b0;
            clipped    <= 1'b0;
            done       <= 1'b0;
        end else if (center) begin
            state      <= S_IDLE;
            acc_x_q    <= ACC_CENTER;
            acc_y_q    <= ACC_CENTER;
            beam_x     <= POS_CENTER;
            beam_y     <= POS_CENTER;
            beam_z     <= '0;
            beam_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            beam_valid <= 1'b0;
            beam_z     <= '0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vec_valid) begin
                        dvx_q   <= dvx;
                        dvy_q   <= dvy;
                        scale_q <= linscale;
                        len_q   <= len;
                        zval_q  <= zval;
                        clipped <= 1'b0;
                        state   <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    step_x_q <= prod_x[20:8];
                    step_y_q <= prod_y[20:8];
                    cnt_q    <= len_q;
                    state    <= (len_q != '0) ? S_DRAW : S_FIN;
                end
                S_DRAW: begin
                    acc_x_q    <= next_x[ACC_W-1:0];
                    acc_y_q    <= next_y[ACC_W-1:0];
                    beam_x     <= next_x[ACC_W-1:FRAC_W];
                    beam_y     <= next_y[ACC_W-1:FRAC_W];
                    clipped    <= clipped | next_x[ACC_W] | next_y[ACC_W];
                    beam_valid <= 1'b1;
                    beam_z     <= zval_q;
                    cnt_q      <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1))
                        state <= S_FIN;
                end
                default: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_beam_integrator.sv
// Directed bench for vector_beam_integrator with a per-cycle reference model of the beam trace.
// The model expands each accepted command into a timeline of expected samples at handshake time.
// Literal checks after each scenario pin positions, latencies and flags independently of the model.
module tb_vector_beam_integrator;

    logic        clk;
    logic        reset_n;
    logic        vec_valid;
    logic        vec_ready;
    logic [12:0] dvx, dvy;
    logic [7:0]  linscale;
    logic [9:0]  len;
    logic [3:0]  zval;
    logic        center;
    logic [9:0]  beam_x, beam_y;
    logic [3:0]  beam_z;
    logic        beam_valid, clipped, done;

    vector_beam_integrator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .dvx        (dvx),
        .dvy        (dvy),
        .linscale   (linscale),
        .len        (len),
        .zval       (zval),
        .center     (center),
        .beam_x     (beam_x),
        .beam_y     (beam_y),
        .beam_z     (beam_z),
        .beam_valid (beam_valid),
        .clipped    (clipped),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edges since reset release; edge n is the clock edge that captures a command.
    int edge_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    // ---------------- reference model ----------------
    localparam int ONE   = 4096;          // one pixel in accumulator units
    localparam int LIMIT = 1024 * ONE;    // first out-of-range accumulator value

    typedef struct {
        int cyc;
        bit valid;
        bit dn;
        int x;
        int y;
        int z;
        bit clip;
    } ev_t;

    ev_t evq[$];
    ev_t ev;
    int  e_x, e_y, e_z;
    bit  e_valid, e_done, e_clip, exp_ready;
    int  m_acc_x, m_acc_y, idle_from;

    function automatic int floor_div256(input int v);
        int q;
        q = v / 256;
        if (v < 0 && (v % 256) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v >= LIMIT) return 1023 * ONE;
        return v;
    endfunction

    function automatic bit out_of_range(input int v);
        return (v < 0) || (v >= LIMIT);
    endfunction

    task automatic push_ev(input int cyc, input bit v, input bit d, input int x, input int y,
                           input int z, input bit c);
        ev_t t;
        t.cyc = cyc; t.valid = v; t.dn = d; t.x = x; t.y = y; t.z = z; t.clip = c;
        evq.push_back(t);
    endtask

    // Expands the command on the inputs, accepted at edge n, into its whole output timeline.
    task automatic plan_vector(input int n);
        int sx, sy, ln;
        bit c;
        sx = floor_div256((int'(dvx) - 4096) * (int'(linscale) + 1));
        sy = floor_div256((int'(dvy) - 4096) * (int'(linscale) + 1));
        ln = int'(len);
        c  = 1'b0;
        push_ev(n, 0, 0, m_acc_x / ONE, m_acc_y / ONE, 0, 0);
        for (int k = 1; k <= ln; k++) begin
            if (out_of_range(m_acc_x + sx) || out_of_range(m_acc_y + sy)) c = 1'b1;
            m_acc_x = sat(m_acc_x + sx);
            m_acc_y = sat(m_acc_y + sy);
            push_ev(n + 1 + k, 1, 0, m_acc_x / ONE, m_acc_y / ONE, int'(zval), c);
        end
        push_ev(n + ln + 2, 0, 1, m_acc_x / ONE, m_acc_y / ONE, 0, c);
        idle_from = n + ln + 2;
    endtask

    // Compare process: apply this edge's expected events, check every output, then plan the next edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            evq.delete();
            e_x = 512; e_y = 512; e_z = 0;
            e_valid = 0; e_done = 0; e_clip = 0;
            m_acc_x = 512 * ONE; m_acc_y = 512 * ONE;
            idle_from = 0;
        end else begin
            e_valid = 0; e_done = 0; e_z = 0;
            while (evq.size() > 0 && evq[0].cyc == edge_cnt) begin
                ev = evq.pop_front();
                e_valid = ev.valid; e_done = ev.dn; e_x = ev.x; e_y = ev.y;
                e_z = ev.z; e_clip = ev.clip;
            end
            exp_ready = (edge_cnt >= idle_from) && !center;
            check("vec_ready",  int'(vec_ready),  int'(exp_ready));
            check("beam_valid", int'(beam_valid), int'(e_valid));
            check("done",       int'(done),       int'(e_done));
            check("beam_x",     int'(beam_x),     e_x);
            check("beam_y",     int'(beam_y),     e_y);
            check("beam_z",     int'(beam_z),     e_z);
            check("clipped",    int'(clipped),    int'(e_clip));
            if (center) begin
                evq.delete();
                push_ev(edge_cnt + 1, 0, 0, 512, 512, 0, e_clip);
                m_acc_x = 512 * ONE; m_acc_y = 512 * ONE;
                idle_from = edge_cnt + 1;
            end else if (vec_valid && exp_ready) begin
                plan_vector(edge_cnt + 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    int hs, hs2, de, nv, nz, cnt_done, cnt_valid;

    // Offers a command; returns the edge on which it was accepted.
    task automatic send(input logic [12:0] x, input logic [12:0] y, input logic [7:0] ls,
                        input logic [9:0] l, input logic [3:0] z, input bit hold,
                        output int hs_edge);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        dvx = x; dvy = y; linscale = ls; len = l; zval = z; vec_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (vec_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("handshake_timeout", int'(got), 1);
        @(posedge clk); #1;
        hs_edge = edge_cnt;
        if (!hold) vec_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, input int zexp, output int done_edge,
                             output int nvalid, output int nzok);
        bit got;
        got = 1'b0; nvalid = 0; nzok = 0; done_edge = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (beam_valid) begin
                nvalid++;
                if (int'(beam_z) == zexp) nzok++;
            end
            if (done) begin
                got = 1'b1;
                done_edge = edge_cnt;
                break;
            end
        end
        check("done_timeout", int'(got), 1);
    endtask

    task automatic pulse_center();
        @(posedge clk); #1 center = 1'b1;
        @(posedge clk); #1 center = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; vec_valid = 1'b0; center = 1'b0;
        dvx = 13'h1000; dvy = 13'h1000; linscale = 8'd0; len = 10'd0; zval = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_beam_x", int'(beam_x), 512);
        check("rst_beam_y", int'(beam_y), 512);
        check("rst_vec_ready", int'(vec_ready), 1);
        check("rst_beam_valid", int'(beam_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_clipped", int'(clipped), 0);
        check("rst_beam_z", int'(beam_z), 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // +256/4096 px per step for 64 steps: +4 px on X
        send(13'h1100, 13'h1000, 8'd255, 10'd64, 4'd7, 1'b0, hs);
        wait_done(200, 7, de, nv, nz);
        check("t1_done_latency", de - hs, 66);
        check("t1_valid_count", nv, 64);
        check("t1_z_count", nz, 64);
        check("t1_beam_x", int'(beam_x), 516);
        check("t1_beam_y", int'(beam_y), 512);

        // -1 px per step for 600 steps from centre: clamps at 0
        pulse_center();
        send(13'h0000, 13'h1000, 8'd255, 10'd600, 4'd3, 1'b0, hs);
        wait_done(800, 3, de, nv, nz);
        check("t2_done_latency", de - hs, 602);
        check("t2_valid_count", nv, 600);
        check("t2_beam_x", int'(beam_x), 0);
        check("t2_beam_y", int'(beam_y), 512);
        check("t2_clipped", int'(clipped), 1);

        // zero-length command: no samples, done right after SCALE, clipped cleared by capture
        send(13'h1100, 13'h1000, 8'd255, 10'd0, 4'd5, 1'b0, hs);
        @(negedge clk);
        check("t3_clip_cleared", int'(clipped), 0);
        wait_done(20, 5, de, nv, nz);
        check("t3_done_latency", de - hs, 2);
        check("t3_valid_count", nv, 0);
        check("t3_beam_x", int'(beam_x), 0);

        // center mid-draw, with a competing command offered in the same cycle
        pulse_center();
        send(13'h1100, 13'h1000, 8'd255, 10'd64, 4'd7, 1'b0, hs);
        nv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (beam_valid) nv++;
            if (nv == 10) break;
        end
        check("t4_reached_step10", nv, 10);
        @(posedge clk); #1;
        center = 1'b1; vec_valid = 1'b1; dvx = 13'h0F00; len = 10'd5; zval = 4'd2;
        @(posedge clk); #1;
        center = 1'b0; vec_valid = 1'b0;
        @(negedge clk);
        check("t4_beam_x", int'(beam_x), 512);
        check("t4_beam_y", int'(beam_y), 512);
        check("t4_beam_valid", int'(beam_valid), 0);
        check("t4_vec_ready", int'(vec_ready), 1);
        cnt_done = 0; cnt_valid = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (beam_valid) cnt_valid++;
        end
        check("t4_no_done", cnt_done, 0);
        check("t4_no_samples", cnt_valid, 0);

        // back-to-back with vec_valid held: +4 then -4 px returns to centre
        send(13'h1100, 13'h1000, 8'd255, 10'd64, 4'd7, 1'b1, hs);
        send(13'h0F00, 13'h1000, 8'd255, 10'd64, 4'd7, 1'b1, hs2);
        vec_valid = 1'b0;
        check("t5_throughput", hs2 - hs, 67);
        wait_done(200, 7, de, nv, nz);
        check("t5_done_latency", de - hs2, 66);
        check("t5_valid_count", nv, 64);
        check("t5_beam_x", int'(beam_x), 512);
        check("t5_beam_y", int'(beam_y), 512);

        // asynchronous reset in the middle of a draw
        send(13'h1100, 13'h1000, 8'd255, 10'd64, 4'd7, 1'b0, hs);
        repeat (20) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t6_beam_x", int'(beam_x), 512);
        check("t6_beam_valid", int'(beam_valid), 0);
        check("t6_beam_z", int'(beam_z), 0);
        check("t6_vec_ready", int'(vec_ready), 1);
        @(posedge clk); #1 reset_n = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("t6_no_done", cnt_done, 0);
        check("t6_beam_x_after", int'(beam_x), 512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
